// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch responder.
package imem_pkg;

    typedef logic [29:0] word_addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        PF_REQ = 2'd2
    } fetch_state_e;

    // Default for the NOP_INSTR parameter (RISC-V addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

endpackage

// File: rtl/imem_word_buf.sv
// One buffered instruction word: valid bit, word-address tag and data.
// A load takes priority over an invalidate in the same cycle.
module imem_word_buf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inval_i,
    input  logic        load_i,
    input  logic [29:0] tag_i,
    input  logic [31:0] data_i,
    input  logic [29:0] cmp_tag_i,
    output logic        hit_o,
    output logic [31:0] data_o
);

    logic        valid_q;
    logic [29:0] tag_q;
    logic [31:0] data_q;

    // Buffer register: load new word or drop validity
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= tag_i;
            data_q  <= data_i;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (tag_q == cmp_tag_i);
    assign data_o = data_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-side responder for the fetch stage. Serves fetch_addr from a
// one-word line buffer and fills misses from a slow req/ack memory.
// Build option: IMEM_PREFETCH_EN adds a sequential prefetch buffer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no memory transaction; a demand miss launches REQ
// REQ    | demand fill outstanding; mem_req held until mem_ack
// PF_REQ | prefetch of the next sequential word outstanding
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          MAX_WAIT  = 255,
    parameter int          WAIT_W    = 8
) (
    input  logic        stage_clk,
    input  logic        reset_n,
    input  logic [31:0] fetch_addr,
    input  logic        flush,
    output logic [31:0] instr_out,
    output logic        fetch_stall,
    output logic        fetch_misaligned,
    output logic        fetch_err,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    fetch_state_e      state_q, state_d;
    logic [29:0]       mem_addr_q, mem_addr_d;
    logic              discard_q, discard_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic [29:0] fetch_tag;
    logic        line_hit;
    logic [31:0] line_data;
    logic        line_load;
    logic [29:0] line_tag_in;
    logic [31:0] line_data_in;

    assign fetch_tag        = fetch_addr[31:2];
    assign fetch_misaligned = |fetch_addr[1:0];

    imem_word_buf u_line (
        .clk_i     (stage_clk),
        .rst_ni    (reset_n),
        .inval_i   (1'b0),
        .load_i    (line_load),
        .tag_i     (line_tag_in),
        .data_i    (line_data_in),
        .cmp_tag_i (fetch_tag),
        .hit_o     (line_hit),
        .data_o    (line_data)
    );

`ifdef IMEM_PREFETCH_EN
    logic        pf_hit;
    logic [31:0] pf_data;
    logic        pf_load;
    logic        pf_inval;
    logic        pf_promote;
    logic        pend_q, pend_d;
    logic [29:0] pend_tag_q, pend_tag_d;

    imem_word_buf u_pf (
        .clk_i     (stage_clk),
        .rst_ni    (reset_n),
        .inval_i   (pf_inval),
        .load_i    (pf_load),
        .tag_i     (mem_addr_q),
        .data_i    (mem_rdata),
        .cmp_tag_i (fetch_tag),
        .hit_o     (pf_hit),
        .data_o    (pf_data)
    );

    assign pf_promote = !fetch_misaligned && !line_hit && pf_hit;
`endif

    // Zero-latency instruction select and stall decision
    always_comb begin
        instr_out   = NOP_INSTR;
        fetch_stall = 1'b0;
        if (fetch_misaligned) begin
            instr_out = NOP_INSTR;
        end else if (line_hit) begin
            instr_out = line_data;
`ifdef IMEM_PREFETCH_EN
        end else if (pf_hit) begin
            instr_out = pf_data;
`endif
        end else begin
            fetch_stall = 1'b1;
        end
    end

    // Next-state, memory handshake, buffer loads and wait-timeout tracking
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        discard_d    = discard_q;
        wait_d       = wait_q;
        line_load    = 1'b0;
        line_tag_in  = mem_addr_q;
        line_data_in = mem_rdata;
`ifdef IMEM_PREFETCH_EN
        pf_load      = 1'b0;
        pf_inval     = 1'b0;
        pend_d       = pend_q;
        pend_tag_d   = pend_tag_q;
        // A pf hit moves the word into the line and queues the next one.
        // pf_hit implies the pf tag equals fetch_tag.
        if (pf_promote) begin
            line_load    = 1'b1;
            line_tag_in  = fetch_tag;
            line_data_in = pf_data;
            pf_inval     = 1'b1;
            pend_d       = 1'b1;
            pend_tag_d   = fetch_tag + 30'd1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (fetch_stall) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_tag;
                    discard_d  = 1'b0;
                    wait_d     = '0;
`ifdef IMEM_PREFETCH_EN
                end else if (pend_q && !flush && !pf_promote) begin
                    state_d    = PF_REQ;
                    mem_addr_d = pend_tag_q;
                    pend_d     = 1'b0;
                    discard_d  = 1'b0;
                    wait_d     = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    wait_d    = '0;
                    discard_d = 1'b0;
                    if (!discard_q && !flush) begin
                        line_load    = 1'b1;
                        line_tag_in  = mem_addr_q;
                        line_data_in = mem_rdata;
`ifdef IMEM_PREFETCH_EN
                        pend_d       = 1'b1;
                        pend_tag_d   = mem_addr_q + 30'd1;
`endif
                    end
                end else begin
                    if (flush) discard_d = 1'b1;
                    if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
                end
            end
`ifdef IMEM_PREFETCH_EN
            PF_REQ: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    wait_d    = '0;
                    discard_d = 1'b0;
                    if (!discard_q && !flush) pf_load = 1'b1;
                end else begin
                    if (flush) discard_d = 1'b1;
                    if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        err_d = err_q | (wait_d == WAIT_MAX);
    end

    // Control registers
    always_ff @(posedge stage_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

`ifdef IMEM_PREFETCH_EN
    // Pending sequential prefetch target
    always_ff @(posedge stage_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= 1'b0;
            pend_tag_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_tag_q <= pend_tag_d;
        end
    end
`endif

    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder with a latency-programmable memory
// model and a scoreboard of expected instruction words.
module tb_imem_fetch_responder;

    localparam int          MAX_WAIT = 255;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] instr_out;
    logic        fetch_stall;
    logic        fetch_misaligned;
    logic        fetch_err;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    int lat = 3;
    bit hold_ack = 1'b0;
    int k = 0;
    logic [29:0] ack_log[$];
    logic [31:0] exp_q[$];

    imem_fetch_responder dut (
        .stage_clk        (clk),
        .reset_n          (rst_n),
        .fetch_addr       (fetch_addr),
        .flush            (flush),
        .instr_out        (instr_out),
        .fetch_stall      (fetch_stall),
        .fetch_misaligned (fetch_misaligned),
        .fetch_err        (fetch_err),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h0) return 32'h00500093;
        return {a, 2'b11} ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: ack in the lat-th cycle of an outstanding request
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0;
                k = 0;
            end else if (mem_req && !mem_ack && !hold_ack) begin
                k++;
                if (k >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    ack_log.push_back(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEADBEEF;
                k = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for stall to drop, then pop and compare the scoreboard
    task automatic wait_ready(input string tag, output int n);
        n = 0;
        #1;
        while (fetch_stall === 1'b1 && n < 600) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 600) check({tag, " timeout"}, 32'd1, 32'd0);
        check({tag, " data"}, instr_out, exp_q.pop_front());
    endtask

    // Present addr; exp_stalls<0 means "at most one stall cycle"
    task automatic serve(input string tag, input logic [31:0] addr, input int exp_stalls);
        int n;
        @(negedge clk);
        fetch_addr = addr;
        exp_q.push_back((addr[1:0] != 2'b00) ? NOP : mem_word(addr[31:2]));
        wait_ready(tag, n);
        if (exp_stalls >= 0) check({tag, " stalls"}, n, exp_stalls);
        else                 check({tag, " stalls<=1"}, 32'(n <= 1), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_addr = 32'h6;
        #20;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int nacks;
        bit any_req;
        bit req_drop;

        // Reset state
        fetch_addr = 32'h0;
        #12;
        check("rst instr", instr_out, NOP);
        check("rst stall", fetch_stall, 1);
        check("rst mem_req", mem_req, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst err", fetch_err, 0);
        check("rst misaligned", fetch_misaligned, 0);
        fetch_addr = 32'h6;
        #1;
        check("rst stall misaligned", fetch_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold miss on 0, ack latency 3
        lat = 3;
        serve("t1 addr0", 32'h0, 4);
        check("t1 instr", instr_out, 32'h00500093);

        // 2: repeat hit, no request
        nacks = ack_log.size();
        serve("t2 addr0 hit", 32'h0, 0);
        check("t2 mem_req", mem_req, 0);
        check("t2 no ack", ack_log.size(), nacks);

        // 3: flush during demand fill
        gap(12);
        ack_log.delete();
        @(negedge clk);
        fetch_addr = 32'h40;
        #1;
        check("t3 stall", fetch_stall, 1);
        @(negedge clk);
        #1;
        check("t3 mem_req", mem_req, 1);
        check("t3 mem_addr", mem_addr, 30'h10);
        flush = 1'b1;
        fetch_addr = 32'h80;
        exp_q.push_back(mem_word(30'h20));
        @(negedge clk);
        flush = 1'b0;
        wait_ready("t3 addr80", n);
        check("t3 ack0 addr", ack_log[0], 30'h10);
        check("t3 ack1 addr", ack_log[1], 30'h20);
        serve("t3 addr40 miss", 32'h40, 4);

        // 3b: flush coinciding with ack discards the data
        gap(12);
        lat = 1;
        @(negedge clk);
        fetch_addr = 32'h100;
        @(negedge clk);
        #1;
        check("t3b mem_req", mem_req, 1);
        check("t3b mem_addr", mem_addr, 30'h40);
        flush = 1'b1;
        fetch_addr = 32'h40;
        #1;
        check("t3b line hit", instr_out, mem_word(30'h10));
        @(negedge clk);
        #1;
        flush = 1'b0;
        check("t3b line kept", instr_out, mem_word(30'h10));
        check("t3b no stall", fetch_stall, 0);
        serve("t3b addr100 miss", 32'h100, 2);

        // 4: misaligned address
        gap(12);
        serve("t4 misaligned", 32'h6, 0);
        check("t4 misaligned flag", fetch_misaligned, 1);
        any_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (mem_req !== 1'b0) any_req = 1'b1;
        end
        check("t4 no mem_req", any_req, 0);

        // 5: ack withheld past MAX_WAIT
        gap(12);
        lat = 1;
        hold_ack = 1'b1;
        @(negedge clk);
        fetch_addr = 32'h200;
        @(negedge clk);
        #1;
        check("t5 mem_req", mem_req, 1);
        req_drop = 1'b0;
        for (int j = 1; j <= MAX_WAIT; j++) begin
            @(negedge clk);
            #1;
            if (mem_req !== 1'b1 || mem_addr !== 30'h80) req_drop = 1'b1;
            if (j == MAX_WAIT - 1) check("t5 err before", fetch_err, 0);
            if (j == MAX_WAIT)     check("t5 err at max", fetch_err, 1);
        end
        check("t5 req held", req_drop, 0);
        exp_q.push_back(mem_word(30'h80));
        hold_ack = 1'b0;
        wait_ready("t5 late ack", n);
        gap(3);
        check("t5 err sticky", fetch_err, 1);

        // Reset in the middle of a request
        gap(12);
        @(negedge clk);
        fetch_addr = 32'h300;
        @(negedge clk);
        #1;
        check("rst mid req before", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid req drop", mem_req, 0);
        check("rst mid err clr", fetch_err, 0);
        check("rst mid instr", instr_out, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        gap(12);

`ifdef IMEM_PREFETCH_EN
        // 6: sequential prefetch with a 2-cycle memory
        do_reset();
        lat = 2;
        ack_log.delete();
        serve("t6 addr0", 32'h0, 3);
        gap(8);
        serve("t6 addr4", 32'h4, -1);
        gap(8);
        serve("t6 addr8", 32'h8, -1);
        gap(8);
        check("t6 ack count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++) check("t6 pf tag", ack_log[i], 30'(i));
        serve("t6 addr top", 32'hFFFFFFFC, 3);
        gap(8);
        check("t6 wrap tag", ack_log[ack_log.size() - 1], 30'h0);
        serve("t6 addr0 from pf", 32'h0, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
